ex_flag_stage: RTL and testbench
================================

# ex_flag_stage

Execute-stage back end that sits directly downstream of `ARMALU`. It latches the 64-bit ALU result into a valid/ready pipeline buffer and keeps the architectural NZCV flag register, updating it only on flag-setting operations. It also resolves B.cond / CBZ / CBNZ branch decisions for the memory stage.

## Interface
- `WIDTH`, 64: datapath width; must match `ARMALU`.
- `clk` input 1: single clock, all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream presents an ALU result this cycle.
- `in_ready` output 1: stage can accept; transfer on `in_valid && in_ready`.
- `alu_result` input WIDTH: `ARMALU` result.
- `alu_negative`, `alu_zero`, `alu_overflow`, `alu_carry_out` input 1 each: `ARMALU` flags.
- `set_flags` input 1: operation is ADDS/SUBS-class; commit flags on accept.
- `is_bcond`, `is_cbz`, `is_cbnz` input 1 each: branch type of the accepted op.
- `cond` input 4: B.cond condition code.
- `out_valid` output 1: buffered entry available downstream.
- `out_ready` input 1: downstream accepts; transfer on `out_valid && out_ready`.
- `out_result` output WIDTH: result of head entry.
- `out_taken` output 1: branch decision of head entry (0 for non-branches).
- `flags_q` output 4: committed flags {N,Z,C,V}.

## Operation
- Accept: on an accept edge, push {alu_result, taken} into the buffer.
- Flag commit: if `set_flags` is 1 on the accept edge, `flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow}`. Otherwise `flags_q` holds.
- Taken priority: `is_cbz` > `is_cbnz` > `is_bcond` > none.
  - CBZ: taken = `alu_zero`. CBNZ: taken = `!alu_zero`. The ALU runs PASS_B on the register.
- B.cond evaluates the *pre-update* `flags_q`, including when `set_flags` is asserted in the same beat.
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !(C&!Z); 10 GE N==V; 11 LT N!=V.
  - 12 GT !Z&(N==V); 13 LE !(GT); 14 AL 1; 15 NV 1.
- Buffer: 2-entry skid FIFO with a `count` in 0..2.
  - `in_ready = (count != 2)`, derived from registered state only, with no combinational path from `out_ready`.
  - `out_valid = (count != 0)`. Head is the oldest entry.
  - Simultaneous push and pop: count unchanged, order preserved. With count 1, the new entry becomes head the following cycle.
  - Push when full cannot occur because `in_ready` is 0. Pop when empty is ignored.
- Reset (asynchronous, any time, mid-transfer included):
  - count=0, `out_valid`=0, `out_result`=0, `out_taken`=0, `flags_q`=4'b0000.
  - `in_ready`=0 while `reset_n` is low, 1 from the first edge after release.
  - In-flight entries are discarded.

## Timing
- Latency: an entry accepted on edge k is visible on `out_*` after edge k when the buffer was empty (1 cycle).
- `flags_q` reflects a commit starting one cycle after the accept edge. A B.cond accepted in the next beat sees the new flags.
- Throughput: 1 entry/cycle sustained while `out_ready`=1.
- Backpressure: with `out_ready` held low, the stage absorbs 2 entries, then `in_ready` drops on the edge that makes count=2.
- `out_result` and `out_taken` are stable while `out_valid && !out_ready`.

## Configuration
- `EX_FLAG_SKID_EN` defined: 2-entry skid buffer as specified above.
- `EX_FLAG_SKID_EN` undefined: single-entry register.
  - `in_ready = !out_valid || out_ready`, a combinational path from `out_ready`.
  - Full throughput is kept, but there is no registered decoupling.
  - Flag and branch behaviour are identical.

## Test plan
- Reset mid-stream: hold `out_ready`=0, push 2 entries, assert `reset_n`=0 → `out_valid`=0, `flags_q`=0, `in_ready`=0. After release, `in_ready`=1 on the first edge.
- Flag commit: SUBS-style beat with result 0, Z=1, C=1, `set_flags`=1 → `flags_q`=4'b0110 next cycle. A following beat with `set_flags`=0 and N=1 leaves `flags_q`=4'b0110.
- B.cond ordering: `flags_q`=4'b0100; same beat `set_flags`=1 (Z=0), `is_bcond`, `cond`=0 (EQ) → `out_taken`=1, i.e. old flags are used. Next beat EQ → `out_taken`=0.
- CBZ/CBNZ: `alu_result`=0, `alu_zero`=1 with `is_cbz` → `out_taken`=1. With `is_cbnz` → 0. With `is_cbz`, `is_bcond`, `cond`=1 all set → taken=1, since CBZ wins.
- Backpressure (SKID_EN): `out_ready`=0, push 0x1, 0x2 → `in_ready`=0 after second accept. Then `out_ready`=1 → 0x1, 0x2 emerge in order, and `in_ready` returns to 1 after the first pop.
- Condition sweep: for each `flags_q` in 0..15 and `cond` 0..15, `out_taken` matches the table above; GE with N=1,V=1 → 1, LT → 0.

Source files
------------

// File: rtl/ex_flag_stage.sv
// ex_flag_stage: execute-stage back end behind ARMALU.
// It buffers the ALU result together with its branch decision and holds the
// architectural NZCV register.
// Build option EX_FLAG_SKID_EN: when it is defined, the buffer is a 2-entry skid
// FIFO, and in_ready comes from registered state only. When it is undefined,
// the buffer is a single-entry register, and in_ready passes out_ready through.
module ex_flag_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry_out,
    input  logic             set_flags,
    input  logic             is_bcond,
    input  logic             is_cbz,
    input  logic             is_cbnz,
    input  logic [3:0]       cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_taken,
    output logic [3:0]       flags_q
);

    // B.cond truth table over committed flags {N,Z,C,V}
    function automatic logic cond_pass(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cy, v;
        logic r;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'd0:    r = z;
            4'd1:    r = !z;
            4'd2:    r = cy;
            4'd3:    r = !cy;
            4'd4:    r = n;
            4'd5:    r = !n;
            4'd6:    r = v;
            4'd7:    r = !v;
            4'd8:    r = cy && !z;
            4'd9:    r = !(cy && !z);
            4'd10:   r = (n == v);
            4'd11:   r = (n != v);
            4'd12:   r = !z && (n == v);
            4'd13:   r = !(!z && (n == v));
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    logic rdy_en;
    logic push;
    logic pop;
    logic taken_p0;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Branch decision for the incoming beat; B.cond sees flags before this beat's commit
    always_comb begin
        taken_p0 = 1'b0;
        if (is_cbz)
            taken_p0 = alu_zero;
        else if (is_cbnz)
            taken_p0 = !alu_zero;
        else if (is_bcond)
            taken_p0 = cond_pass(flags_q, cond);
    end

    // NZCV register: commits only on accepted flag-setting beats
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            flags_q <= 4'b0000;
        else if (push && set_flags)
            flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
    end

    // Holds in_ready low through reset and until the first edge after release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rdy_en <= 1'b0;
        else
            rdy_en <= 1'b1;
    end

`ifdef EX_FLAG_SKID_EN
    logic [1:0]       count_p1;
    logic [WIDTH-1:0] head_result_p1;
    logic [WIDTH-1:0] tail_result_p1;
    logic             head_taken_p1;
    logic             tail_taken_p1;

    assign in_ready   = rdy_en && (count_p1 != 2'd2);
    assign out_valid  = (count_p1 != 2'd0);
    assign out_result = head_result_p1;
    assign out_taken  = head_taken_p1;

    // Two-slot FIFO: head is always the oldest entry, tail shifts forward on pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_p1       <= 2'd0;
            head_result_p1 <= '0;
            tail_result_p1 <= '0;
            head_taken_p1  <= 1'b0;
            tail_taken_p1  <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_p1 == 2'd0) begin
                        head_result_p1 <= alu_result;
                        head_taken_p1  <= taken_p0;
                    end else begin
                        tail_result_p1 <= alu_result;
                        tail_taken_p1  <= taken_p0;
                    end
                    count_p1 <= count_p1 + 2'd1;
                end
                2'b01: begin
                    head_result_p1 <= tail_result_p1;
                    head_taken_p1  <= tail_taken_p1;
                    count_p1       <= count_p1 - 2'd1;
                end
                2'b11: begin
                    if (count_p1 == 2'd1) begin
                        head_result_p1 <= alu_result;
                        head_taken_p1  <= taken_p0;
                    end else begin
                        head_result_p1 <= tail_result_p1;
                        head_taken_p1  <= tail_taken_p1;
                        tail_result_p1 <= alu_result;
                        tail_taken_p1  <= taken_p0;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    logic             valid_p1;
    logic [WIDTH-1:0] head_result_p1;
    logic             head_taken_p1;

    assign in_ready   = rdy_en && (!valid_p1 || out_ready);
    assign out_valid  = valid_p1;
    assign out_result = head_result_p1;
    assign out_taken  = head_taken_p1;

    // Single pipeline register; a pop and a push in the same beat replace the entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_p1       <= 1'b0;
            head_result_p1 <= '0;
            head_taken_p1  <= 1'b0;
        end else if (push) begin
            valid_p1       <= 1'b1;
            head_result_p1 <= alu_result;
            head_taken_p1  <= taken_p0;
        end else if (pop) begin
            valid_p1 <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ex_flag_stage.sv
// Testbench for ex_flag_stage. It uses directed vectors, a queue-based reference
// model, and a per-cycle comparison against that model.
module tb_ex_flag_stage;

    localparam int WIDTH = 64;
`ifdef EX_FLAG_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_result;
    logic             alu_negative;
    logic             alu_zero;
    logic             alu_overflow;
    logic             alu_carry_out;
    logic             set_flags;
    logic             is_bcond;
    logic             is_cbz;
    logic             is_cbnz;
    logic [3:0]       cond;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_taken;
    logic [3:0]       flags_q;

    ex_flag_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
        .set_flags(set_flags), .is_bcond(is_bcond), .is_cbz(is_cbz),
        .is_cbnz(is_cbnz), .cond(cond),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_taken(out_taken), .flags_q(flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. It keeps a queue of entries plus the committed flags.
    typedef struct packed {
        logic [63:0] r;
        logic        t;
    } ent_t;

    ent_t       q[$];
    logic [3:0] m_flags;
    logic       m_alive;

    // ARM condition evaluation. The base test is selected by cond[3:1], and
    // cond[0] inverts it, except for 1111.
    function automatic logic cond_true(input logic [3:0] f, input logic [3:0] c);
        logic r;
        case (c[3:1])
            3'd0: r = f[2];
            3'd1: r = f[1];
            3'd2: r = f[3];
            3'd3: r = f[0];
            3'd4: r = f[1] && !f[2];
            3'd5: r = (f[3] == f[0]);
            3'd6: r = (f[3] == f[0]) && !f[2];
            default: r = 1'b1;
        endcase
        if (c[0] && c != 4'hF) r = !r;
        return r;
    endfunction

    function automatic logic model_rdy();
        if (!m_alive) return 1'b0;
        if (SKID) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    function automatic ent_t make_entry();
        ent_t e;
        e.r = alu_result;
        if (is_cbz)        e.t = alu_zero;
        else if (is_cbnz)  e.t = !alu_zero;
        else if (is_bcond) e.t = cond_true(m_flags, cond);
        else               e.t = 1'b0;
        return e;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_flags <= 4'b0000;
            m_alive <= 1'b0;
        end else begin
            if (in_valid && model_rdy()) begin
                if (set_flags)
                    m_flags <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                q.push_back(make_entry());
            end else if (q.size() != 0 && out_ready) begin
                void'(q.pop_front());
            end
            m_alive <= 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("in_ready", {63'd0, in_ready}, {63'd0, model_rdy()});
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
        chk("flags_q", {60'd0, flags_q}, {60'd0, m_flags});
        if (q.size() != 0) begin
            chk("out_result", out_result, q[0].r);
            chk("out_taken", {63'd0, out_taken}, {63'd0, q[0].t});
        end
    end

    task automatic beat(input logic [63:0] res, input logic [3:0] nzcv, input logic sf,
                        input logic cz, input logic cnz, input logic bc, input logic [3:0] cd);
        in_valid   = 1'b1;
        alu_result = res;
        {alu_negative, alu_zero, alu_carry_out, alu_overflow} = nzcv;
        set_flags  = sf;
        is_cbz     = cz;
        is_cbnz    = cnz;
        is_bcond   = bc;
        cond       = cd;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        set_flags = 1'b0;
        is_cbz    = 1'b0;
        is_cbnz   = 1'b0;
        is_bcond  = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0; alu_result = '0;
        alu_negative = 0; alu_zero = 0; alu_overflow = 0; alu_carry_out = 0;
        set_flags = 0; is_bcond = 0; is_cbz = 0; is_cbnz = 0; cond = 4'd0;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_flags", {60'd0, flags_q}, 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        reset_n = 1'b1;
        idle();
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Flag commit
        beat(64'd0, 4'b0110, 1, 0, 0, 0, 4'd0);
        chk("subs_flags", {60'd0, flags_q}, 64'h6);
        chk("subs_result", out_result, 64'd0);
        beat(64'h8000_0000_0000_0000, 4'b1000, 0, 0, 0, 0, 4'd0);
        chk("noset_flags", {60'd0, flags_q}, 64'h6);
        chk("noset_result", out_result, 64'h8000_0000_0000_0000);

        // B.cond uses flags from before the same-beat commit
        beat(64'd5, 4'b0100, 1, 0, 0, 0, 4'd0);
        chk("z_only_flags", {60'd0, flags_q}, 64'h4);
        beat(64'd7, 4'b0000, 1, 0, 0, 1, 4'd0);
        chk("bcond_old_flags", {63'd0, out_taken}, 64'd1);
        chk("bcond_commit", {60'd0, flags_q}, 64'h0);
        beat(64'd9, 4'b0000, 0, 0, 0, 1, 4'd0);
        chk("bcond_new_flags", {63'd0, out_taken}, 64'd0);

        // CBZ / CBNZ priority
        beat(64'd0, 4'b0100, 0, 1, 0, 0, 4'd0);
        chk("cbz_taken", {63'd0, out_taken}, 64'd1);
        beat(64'd0, 4'b0100, 0, 0, 1, 0, 4'd0);
        chk("cbnz_not", {63'd0, out_taken}, 64'd0);
        beat(64'd0, 4'b0100, 0, 1, 0, 1, 4'd0);
        chk("cbz_over_bcond", {63'd0, out_taken}, 64'd1);
        beat(64'd3, 4'b0000, 0, 1, 1, 1, 4'd14);
        chk("cbz_over_all", {63'd0, out_taken}, 64'd0);
        beat(64'd3, 4'b0000, 0, 0, 1, 1, 4'd0);
        chk("cbnz_over_bcond", {63'd0, out_taken}, 64'd1);

        // Condition sweep over every flag value and condition code
        for (int f = 0; f < 16; f++) begin
            beat(64'(f), 4'(f), 1, 0, 0, 0, 4'd0);
            for (int c = 0; c < 16; c++) begin
                beat(64'(256 + c), 4'b0000, 0, 0, 0, 1, 4'(c));
                if (f == 9 && c == 10) chk("ge_n1_v1", {63'd0, out_taken}, 64'd1);
                if (f == 9 && c == 11) chk("lt_n1_v1", {63'd0, out_taken}, 64'd0);
                if (f == 4 && c == 13) chk("le_z1", {63'd0, out_taken}, 64'd1);
                if (f == 2 && c == 8)  chk("hi_c1_z0", {63'd0, out_taken}, 64'd1);
            end
        end

        // Mixed traffic with toggling backpressure
        for (int i = 0; i < 80; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0)
                beat({$urandom, $urandom}, 4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom));
            else
                idle();
        end
        out_ready = 1'b1;
        repeat (3) idle();

        // Backpressure and drain order
        out_ready = 1'b0;
        beat(64'h1, 4'b0000, 0, 0, 0, 0, 4'd0);
        if (SKID) begin
            chk("bp_ready_after_1", {63'd0, in_ready}, 64'd1);
            beat(64'h2, 4'b0000, 0, 0, 0, 0, 4'd0);
            chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_head", out_result, 64'h1);
            idle();
            chk("bp_head_stable", out_result, 64'h1);
            out_ready = 1'b1;
            idle();
            chk("bp_second", out_result, 64'h2);
            chk("bp_ready_back", {63'd0, in_ready}, 64'd1);
            idle();
            chk("bp_drained", {63'd0, out_valid}, 64'd0);
        end else begin
            chk("bp_single_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_single_head", out_result, 64'h1);
            out_ready = 1'b1;
            #1;
            chk("bp_single_passthru", {63'd0, in_ready}, 64'd1);
            idle();
            chk("bp_single_drained", {63'd0, out_valid}, 64'd0);
        end

        // Asynchronous reset in the middle of a stalled stream
        beat(64'hF0, 4'b1111, 1, 0, 0, 0, 4'd0);
        chk("pre_rst_flags", {60'd0, flags_q}, 64'hF);
        out_ready = 1'b0;
        beat(64'hA, 4'b0000, 0, 0, 0, 0, 4'd0);
        beat(64'hB, 4'b0000, 0, 0, 0, 0, 4'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_flags", {60'd0, flags_q}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("mid_rst_result", out_result, 64'd0);
        chk("mid_rst_taken", {63'd0, out_taken}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #1;
        chk("release_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        chk("first_edge_in_ready", {63'd0, in_ready}, 64'd1);
        chk("first_edge_out_valid", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        beat(64'h55, 4'b0001, 1, 0, 0, 0, 4'd6);
        chk("after_rst_result", out_result, 64'h55);
        chk("after_rst_flags", {60'd0, flags_q}, 64'h1);
        repeat (2) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
